// File: rtl/stack_spill_cache_pkg.sv
// Shared constants for the spill-cached stack: FSM state encodings and op decode.
package stack_spill_cache_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SPILL = 2'd1;
  localparam state_t FILL  = 2'd2;

  typedef logic [1:0] op_t;
  localparam op_t OP_NONE    = 2'd0;
  localparam op_t OP_PUSH    = 2'd1;
  localparam op_t OP_POP     = 2'd2;
  localparam op_t OP_REPLACE = 2'd3;

  // change & ~dec & ~update is deliberately a no-op.
  function automatic op_t decode_op(input logic change, input logic dec, input logic update);
    if (change && dec)     return OP_POP;
    if (change && update)  return OP_PUSH;
    if (!change && update) return OP_REPLACE;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_spill_cache_if.sv
// Single-port spill memory handshake: the stack is master, the memory is slave.
interface stack_spill_cache_if #(
  parameter int WIDTH  = 16,
  parameter int MEM_AW = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/stack_cache_ring.sv
// Circular register file holding the newest CACHE_DEPTH stack entries.
module stack_cache_ring #(
  parameter int WIDTH       = 16,
  parameter int CACHE_DEPTH = 4,
  localparam int PW         = $clog2(CACHE_DEPTH),
  localparam int CNT_W      = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic             fill_bottom,
  input  logic             drop_oldest,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] fill_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] oldest,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] ring [CACHE_DEPTH];
  logic [PW-1:0]    head;

  // NOTE: the data array has no reset; cnt==0 marks every slot invalid, so
  // clearing it would only cost flops/muxes without changing behaviour.
  always_ff @(posedge clk) begin
    if (push)             ring[head + PW'(1)] <= d;
    else if (replace)     ring[head]          <= d;
    else if (fill_bottom) ring[head - PW'(cnt)] <= fill_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      cnt  <= '0;
    end else if (push) begin
      head <= head + PW'(1);
      cnt  <= cnt + CNT_W'(1);
    end else if (pop) begin
      head <= head - PW'(1);
      cnt  <= cnt - CNT_W'(1);
    end else if (fill_bottom) begin
      cnt  <= cnt + CNT_W'(1);
    end else if (drop_oldest) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign top    = (cnt == '0) ? '0 : ring[head];
  assign oldest = ring[head - PW'(cnt - CNT_W'(1))];

endmodule

// File: rtl/stack_spill_cache.sv
// Stack with a register-ring cache that spills/fills its oldest entries to external memory.
module stack_spill_cache
  import stack_spill_cache_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CACHE_DEPTH = 4,
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_AW      = $clog2(MEM_DEPTH),
  parameter int DEPTH_W     = $clog2(CACHE_DEPTH + MEM_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   D,
  input  logic               dec,
  input  logic               change,
  input  logic               update,
  input  logic               clear_err,
  output logic [WIDTH-1:0]   Q,
  output logic               stall,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow,
  stack_spill_cache_if.master mem_bus
);

  localparam int CNT_W = $clog2(CACHE_DEPTH) + 1;
  localparam int SP_W  = MEM_AW + 1;

  state_t            state;
  op_t               op;
  logic [CNT_W-1:0]  cache_cnt;
  logic [SP_W-1:0]   spilled;
  logic [SP_W-1:0]   spilled_m1;
  logic [WIDTH-1:0]  oldest;
  logic              is_push, is_pop, is_replace;
  logic              cache_full, stack_full, stack_empty;
  logic              need_spill, need_fill, accept;
  logic              req_q, we_q;
  logic [MEM_AW-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;

  assign op          = decode_op(change, dec, update);
  assign is_push     = (op == OP_PUSH);
  assign is_pop      = (op == OP_POP);
  assign is_replace  = (op == OP_REPLACE);
  assign spilled_m1  = spilled - SP_W'(1);

  // cache_cnt is never 0 while anything is spilled, so it alone decides emptiness.
  assign cache_full  = (cache_cnt == CNT_W'(CACHE_DEPTH));
  assign stack_full  = cache_full && (spilled == SP_W'(MEM_DEPTH));
  assign stack_empty = (cache_cnt == '0);
  assign need_spill  = is_push && cache_full && (spilled < SP_W'(MEM_DEPTH));
  assign need_fill   = is_pop && (cache_cnt == CNT_W'(1)) && (spilled != '0);
  assign stall       = (state != IDLE) || need_spill || need_fill;
  assign accept      = !stall;

  stack_cache_ring #(
    .WIDTH      (WIDTH),
    .CACHE_DEPTH(CACHE_DEPTH)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .push       (accept && is_push && !stack_full),
    .pop        (accept && is_pop && !stack_empty),
    .replace    (accept && is_replace && !stack_empty),
    .fill_bottom(state == FILL && mem_bus.mem_ack),
    .drop_oldest(state == SPILL && mem_bus.mem_ack),
    .d          (D),
    .fill_data  (mem_bus.mem_rdata),
    .top        (Q),
    .oldest     (oldest),
    .cnt        (cache_cnt)
  );

  // A new error in the same cycle as clear_err wins, so the flag stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !clear_err) || (accept && is_push && stack_full);
      underflow <= (underflow && !clear_err) ||
                   (accept && (is_pop || is_replace) && stack_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      spilled <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (need_spill) begin
            state   <= SPILL;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= spilled[MEM_AW-1:0];
            wdata_q <= oldest;
          end else if (need_fill) begin
            state   <= FILL;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= spilled_m1[MEM_AW-1:0];
          end
        end
        SPILL: if (mem_bus.mem_ack) begin
          state   <= IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          spilled <= spilled + SP_W'(1);
        end
        FILL: if (mem_bus.mem_ack) begin
          state   <= IDLE;
          req_q   <= 1'b0;
          spilled <= spilled_m1;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign depth             = DEPTH_W'(cache_cnt) + DEPTH_W'(spilled);
  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_stack_spill_cache.sv
// Directed bench for stack_spill_cache with CACHE_DEPTH=4, MEM_DEPTH=8 and a delayed-ack memory model.
module tb_stack_spill_cache;

  localparam int WIDTH = 16;
  localparam int MEM_AW = 3;
  localparam int DEPTH_W = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [WIDTH-1:0]   D = '0;
  logic               dec = 1'b0, change = 1'b0, update = 1'b0, clear_err = 1'b0;
  logic [WIDTH-1:0]   Q;
  logic               stall, overflow, underflow;
  logic [DEPTH_W-1:0] depth;

  int pass_cnt = 0;
  int total_cnt = 0;

  stack_spill_cache_if #(.WIDTH(WIDTH), .MEM_AW(MEM_AW)) mem_bus ();

  stack_spill_cache #(
    .WIDTH(WIDTH), .CACHE_DEPTH(4), .MEM_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .D(D), .dec(dec), .change(change), .update(update),
    .clear_err(clear_err), .Q(Q), .stall(stall), .depth(depth),
    .overflow(overflow), .underflow(underflow), .mem_bus(mem_bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack arrives after the request has been held ack_delay cycles.
  logic [WIDTH-1:0]  spill_mem [8];
  int                ack_delay = 2;
  int                req_age = 0;
  int                req_cycles = 0;
  logic [MEM_AW-1:0] last_waddr = '0, last_raddr = '0;
  logic [WIDTH-1:0]  last_wdata = '0;

  assign mem_bus.mem_ack   = mem_bus.mem_req && (req_age >= ack_delay);
  assign mem_bus.mem_rdata = spill_mem[mem_bus.mem_addr];

  always @(posedge clk) begin
    if (mem_bus.mem_req && !mem_bus.mem_ack) req_age <= req_age + 1;
    else req_age <= 0;
    if (mem_bus.mem_req) req_cycles <= req_cycles + 1;
    if (mem_bus.mem_req && mem_bus.mem_ack && mem_bus.mem_we) begin
      spill_mem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      last_waddr <= mem_bus.mem_addr;
      last_wdata <= mem_bus.mem_wdata;
    end
    if (mem_bus.mem_req && mem_bus.mem_ack && !mem_bus.mem_we) last_raddr <= mem_bus.mem_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_inputs();
    change = 1'b0; dec = 1'b0; update = 1'b0; clear_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive one op, hold it while stalled, return after the accepting edge.
  task automatic do_op(input logic c, input logic dc, input logic u, input logic [WIDTH-1:0] data,
                       input logic clr, output int stall_cycles);
    logic accepted;
    accepted = 1'b0;
    stall_cycles = 0;
    @(negedge clk);
    change = c; dec = dc; update = u; D = data; clear_err = clr;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall) begin
        accepted = 1'b1;
        break;
      end
      stall_cycles++;
      @(negedge clk);
    end
    if (!accepted) check("op_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic push(input logic [WIDTH-1:0] data, output int sc);
    do_op(1'b1, 1'b0, 1'b1, data, 1'b0, sc);
  endtask

  task automatic pop(output int sc);
    do_op(1'b1, 1'b1, 1'b0, '0, 1'b0, sc);
  endtask

  typedef struct {
    logic               c, dc, u;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   q;
    logic [DEPTH_W-1:0] dep;
    logic               uf;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int sc, rc0;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 4'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'd2, 16'd2, 4'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'd3, 16'd3, 4'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'd4, 16'd4, 4'd4, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'd0, 16'd3, 4'd3, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 4'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 4'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'd9, 16'd0, 4'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'd7, 16'd0, 4'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'd5, 16'd5, 4'd1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'd6, 16'd6, 4'd1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'd8, 16'd0, 4'd0, 1'b1};

    // Reset state
    do_reset();
    check("reset_q", 32'(Q), 32'd0);
    check("reset_depth", 32'(depth), 32'd0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    check("reset_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);

    // Table: in-cache pushes/pops/replace, empty-stack errors; never stalls or touches memory
    rc0 = req_cycles;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      change = vecs[i].c; dec = vecs[i].dc; update = vecs[i].u; D = vecs[i].d;
      #1 check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].q));
      check($sformatf("vec%0d_depth", i), 32'(depth), 32'(vecs[i].dep));
      check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].uf));
      clear_inputs();
    end
    check("table_no_mem_req", 32'(req_cycles - rc0), 32'd0);

    // Pop and replace on empty stack after reset
    do_reset();
    pop(sc);
    check("empty_pop_uf", 32'(underflow), 32'd1);
    check("empty_pop_q", 32'(Q), 32'd0);
    check("empty_pop_depth", 32'(depth), 32'd0);
    do_reset();
    check("reset_clears_uf", 32'(underflow), 32'd0);
    do_op(1'b0, 1'b0, 1'b1, 16'd7, 1'b0, sc);
    check("empty_repl_uf", 32'(underflow), 32'd1);
    check("empty_repl_q", 32'(Q), 32'd0);
    check("empty_repl_depth", 32'(depth), 32'd0);

    // Spill on 5th push (ack delayed 2 cycles), then fill on 4th pop
    do_reset();
    for (int k = 1; k <= 4; k++) push(WIDTH'(k), sc);
    rc0 = req_cycles;
    push(16'd5, sc);
    check("spill_stalled", 32'(sc > 0), 32'd1);
    check("spill_req_cycles", 32'(req_cycles - rc0), 32'd3);
    check("spill_addr", 32'(last_waddr), 32'd0);
    check("spill_data", 32'(last_wdata), 32'd1);
    check("spill_q", 32'(Q), 32'd5);
    check("spill_depth", 32'(depth), 32'd5);
    for (int k = 0; k < 3; k++) begin
      pop(sc);
      check($sformatf("prefill_pop%0d_nostall", k), 32'(sc), 32'd0);
      check($sformatf("prefill_pop%0d_q", k), 32'(Q), 32'(4 - k));
    end
    pop(sc);
    check("fill_stalled", 32'(sc > 0), 32'd1);
    check("fill_addr", 32'(last_raddr), 32'd0);
    check("fill_q", 32'(Q), 32'd1);
    check("fill_depth", 32'(depth), 32'd1);

    // Fill to full, overflow, clear_err interplay, then drain through fills
    do_reset();
    for (int k = 1; k <= 12; k++) push(WIDTH'(k), sc);
    check("full_depth", 32'(depth), 32'd12);
    check("full_q", 32'(Q), 32'd12);
    rc0 = req_cycles;
    push(16'd13, sc);
    check("ovf_nostall", 32'(sc), 32'd0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_depth", 32'(depth), 32'd12);
    check("ovf_q", 32'(Q), 32'd12);
    check("ovf_no_mem", 32'(req_cycles - rc0), 32'd0);
    do_op(1'b1, 1'b0, 1'b1, 16'd14, 1'b1, sc);
    check("ovf_clear_same_cycle", 32'(overflow), 32'd1);
    do_op(1'b0, 1'b0, 1'b0, '0, 1'b1, sc);
    check("ovf_cleared", 32'(overflow), 32'd0);
    for (int k = 11; k >= 0; k--) begin
      pop(sc);
      check($sformatf("drain_q%0d", k), 32'(Q), 32'(k));
    end
    check("drain_depth", 32'(depth), 32'd0);
    check("drain_no_uf", 32'(underflow), 32'd0);

    // Reset while a spill is waiting for ack
    do_reset();
    ack_delay = 100;
    for (int k = 1; k <= 4; k++) push(WIDTH'(k), sc);
    @(negedge clk);
    change = 1'b1; update = 1'b1; D = 16'd5;
    @(posedge clk);
    #1;
    check("abort_req_up", 32'(mem_bus.mem_req), 32'd1);
    check("abort_req_we", 32'(mem_bus.mem_we), 32'd1);
    check("abort_req_data", 32'(mem_bus.mem_wdata), 32'd1);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_req_low", 32'(mem_bus.mem_req), 32'd0);
    check("abort_depth", 32'(depth), 32'd0);
    check("abort_q", 32'(Q), 32'd0);

    // Same-cycle ack: single-cycle memory transaction
    ack_delay = 0;
    for (int k = 1; k <= 4; k++) push(WIDTH'(k), sc);
    rc0 = req_cycles;
    push(16'd5, sc);
    check("fast_req_cycles", 32'(req_cycles - rc0), 32'd1);
    check("fast_spill_data", 32'(last_wdata), 32'd1);
    check("fast_q", 32'(Q), 32'd5);
    check("fast_depth", 32'(depth), 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
